operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Sits directly downstream of dec_to_bin in the calculator datapath.
- Consumes the 4-bit binary digit `res` plus a key-activity level `key_any`, which is the OR of the ten digit key lines.
- Accumulates successive key presses into a multi-digit binary operand: value = value*10 + digit.
- Accepts one digit per press and ignores held keys until they are released; feeds the operand register of the ALU stage.

Parameters:
- MAX_DIGITS, 4, maximum number of significant decimal digits accepted.
- WIDTH, 14, operand width in bits; must satisfy 10^MAX_DIGITS - 1 < 2^WIDTH.
- DEBOUNCE_CYCLES, 4, consecutive stable samples required (used only with the debounce feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- key_any  in  1  level; high while any digit key is pressed.
- digit  in  4  binary digit from dec_to_bin; valid while key_any is high.
- clear  in  1  synchronous operand clear, one-cycle pulse.
- value  out  WIDTH  accumulated operand, registered.
- ndigits  out  $clog2(MAX_DIGITS+1)  count of significant digits entered.
- full  out  1  high when ndigits == MAX_DIGITS.
- digit_stb  out  1  one-cycle pulse, the cycle value/ndigits show an accepted digit.
- err  out  1  sticky; set when digit > 9 is presented on acceptance.

Behaviour:
- Reset (rst=1 at a clock edge):
  - value=0, ndigits=0, full=0, digit_stb=0, err=0.
  - FSM goes to IDLE; debounce state is cleared to "released".
  - Reset mid-press: the FSM goes to IDLE and the key is re-accepted only if key_any is still high after reset. The bench holds key_any low across reset.
- FSM states are IDLE and WAIT_REL. "kl" denotes key_any, or the debounced level when the feature is enabled.
- IDLE, kl=1: evaluate the digit sampled that cycle, then go to WAIT_REL.
  - digit > 9: set err; value and ndigits unchanged; no strobe.
  - full=1: reject the digit; value unchanged; no strobe; err unchanged.
  - value==0 and digit==0 (leading zero): value stays 0, ndigits unchanged, digit_stb pulses.
  - Otherwise: value <= value*10 + digit and ndigits <= ndigits+1, both visible the next cycle together with digit_stb=1.
  - Arithmetic: compute value*10 as (value<<3)+(value<<1) at WIDTH+4 bits and truncate to WIDTH. The full-guard guarantees no overflow.
- WAIT_REL: wait for kl=0, then go to IDLE. Digit changes while held are ignored.
- Latency without debounce: key_any rises in cycle N → value and digit_stb update in cycle N+1.
- clear=1:
  - Zeroes value, ndigits, full and err the next cycle. digit_stb=0 that cycle.
  - FSM state is NOT changed, so a key held across clear is not re-entered.
  - clear has priority over a simultaneous acceptance; that digit is dropped.
- full is combinational from the registered ndigits (ndigits == MAX_DIGITS).

Optional Feature:
- Macro: OPERAND_ENTRY_DEBOUNCE_EN.
- When defined:
  - key_any passes through a debouncer before the FSM.
  - The debounced level toggles only after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level; any matching sample resets the counter.
  - The digit is sampled in the cycle the debounced level rises.
  - Latency: key_any stable-high from cycle N → digit_stb at cycle N+DEBOUNCE_CYCLES+1.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- When undefined: kl = key_any directly; no counter is instantiated and DEBOUNCE_CYCLES is unused.

Decomposition:
- Shared package calc_pkg holds:
  - DIGIT_W=4 and MAX_DEC_DIGIT=4'd9;
  - the FSM state enum entry_state_t {IDLE, WAIT_REL}, reused by later entry/operator stages.
- One sub-module, key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, in, out), instantiated only under the macro.

Test Plan:
- Press 1, release, press 3, release (each 2+ cycles) → value=13, ndigits=2, two digit_stb pulses, err=0.
- Press 0, 0, 7 → value=7, ndigits=1, three digit_stb pulses.
- MAX_DIGITS=4: enter 9,8,7,6 then 5 → value=9876, full=1, fifth press gives no strobe and no change.
- Hold key 4 for 10 cycles while digit changes to 6 → value=4 and a single strobe. Then assert clear with key still held → value=0, no re-entry until the key is released and pressed again.
- Force digit=4'hC with key_any pulse → err=1, value unchanged. Then clear → err=0.
- With OPERAND_ENTRY_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - a 3-cycle key_any glitch gives no strobe;
  - a 6-cycle press of digit 2 gives value=2 with the strobe exactly 5 cycles after the rise.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types and digit constants
package calc_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DEC_DIGIT = 4'd9;

  // Entry FSM states, shared with the later entry/operator stages
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } entry_state_t;

  function automatic logic is_dec_digit(input logic [DIGIT_W-1:0] d);
    return d <= MAX_DEC_DIGIT;
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// rtl/operand_entry_if.sv - key/digit inputs and operand outputs of the entry stage
interface operand_entry_if #(
  parameter int WIDTH = 14,
  parameter int NDW   = 3
);

  logic                         key_any;
  logic [calc_pkg::DIGIT_W-1:0] digit;
  logic                         clear;
  logic [WIDTH-1:0]             value;
  logic [NDW-1:0]               ndigits;
  logic                         full;
  logic                         digit_stb;
  logic                         err;

  modport master (
    output key_any, digit, clear,
    input  value, ndigits, full, digit_stb, err
  );

  modport slave (
    input  key_any, digit, clear,
    output value, ndigits, full, digit_stb, err
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - level debouncer, toggles after DEBOUNCE_CYCLES differing samples
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Any sample matching the current level restarts the run
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 1'b0;
      cnt <= '0;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      out <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - accumulates decimal key presses into a binary operand
// Optional key debouncer enabled by OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS      = 4,
  parameter int WIDTH           = 14,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  operand_entry_if.slave  bus
);

  localparam int NDW = $clog2(MAX_DIGITS + 1);

  logic                 kl;
  entry_state_t         state, state_nx;
  logic [WIDTH-1:0]     value_q;
  logic [NDW-1:0]       ndigits_q;
  logic                 stb_q, err_q, full;
  logic                 take, bad, lead_zero, push;
  logic [WIDTH+3:0]     ext, prod;

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk (clk),
    .rst (rst),
    .in  (bus.key_any),
    .out (kl)
  );
`else
  assign kl = bus.key_any;
`endif

  assign full = (ndigits_q == NDW'(MAX_DIGITS));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (kl)  state_nx = WAIT_REL;
      WAIT_REL: if (!kl) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  // Classify the digit seen on the press edge; an out-of-range code wins over full
  always_comb begin
    take      = (state == IDLE) && kl;
    bad       = take && !is_dec_digit(bus.digit);
    lead_zero = take && !bad && !full && (value_q == '0) && (bus.digit == '0);
    push      = take && !bad && !full && !lead_zero;
  end

  assign ext  = {4'b0000, value_q};
  assign prod = (ext << 3) + (ext << 1) + (WIDTH+4)'(bus.digit);

  // clear outranks a simultaneous acceptance but leaves the FSM alone
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= '0;
      ndigits_q <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (bus.clear) begin
      value_q   <= '0;
      ndigits_q <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stb_q <= push || lead_zero;
      if (bad) err_q <= 1'b1;
      if (push) begin
        value_q   <= prod[WIDTH-1:0];
        ndigits_q <= ndigits_q + 1'b1;
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.ndigits   = ndigits_q;
  assign bus.full      = full;
  assign bus.digit_stb = stb_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - vector table, hand sequences and random presses against a model
module tb_operand_entry;

  localparam int MAXD = 4;
  localparam int W    = 14;
  localparam int DEB  = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_entry_if #(.WIDTH(W), .NDW(3)) bus ();

  operand_entry #(
    .MAX_DIGITS(MAXD), .WIDTH(W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_clear;
    logic [3:0] d;
    int         v;
    int         n;
    int         e;
    int         s;
  } vec_t;

  vec_t tab [15];
  int errors = 0;
  int checks = 0;
  int stbs, first_stb;
  int mv, mn, merr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int idx);
    @(posedge clk);
    #1;
    if (bus.digit_stb === 1'b1) begin
      stbs++;
      if (first_stb < 0) first_stb = idx;
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int rel);
    stbs = 0; first_stb = -1;
    bus.key_any = 1'b1; bus.digit = d;
    for (int i = 0; i < hold; i++) step(i);
    bus.key_any = 1'b0; bus.digit = 4'($urandom_range(0, 15));
    for (int i = 0; i < rel; i++) step(hold + i);
  endtask

  task automatic do_clear();
    stbs = 0; first_stb = -1;
    bus.clear = 1'b1;
    step(0);
    bus.clear = 1'b0;
  endtask

  task automatic check_state(input string tag, input int v, input int n, input int e);
    chk({tag, " value"},   int'(bus.value),   v);
    chk({tag, " ndigits"}, int'(bus.ndigits), n);
    chk({tag, " full"},    int'(bus.full),    int'(n == MAXD));
    chk({tag, " err"},     int'(bus.err),     e);
  endtask

  // Reference: one press applies the decimal entry rules to the operand as a number
  task automatic model_press(input int d, output int s);
    s = 0;
    if (d > 9) merr = 1;
    else if (mn == MAXD) s = 0;
    else if (mv == 0 && d == 0) s = 1;
    else begin
      mv = mv * 10 + d;
      mn = mn + 1;
      s  = 1;
    end
  endtask

  initial begin
    int s, d;
    tab[0]  = '{0, 4'd1,  1,    1, 0, 1};
    tab[1]  = '{0, 4'd3,  13,   2, 0, 1};
    tab[2]  = '{1, 4'd0,  0,    0, 0, 0};
    tab[3]  = '{0, 4'd0,  0,    0, 0, 1};
    tab[4]  = '{0, 4'd0,  0,    0, 0, 1};
    tab[5]  = '{0, 4'd7,  7,    1, 0, 1};
    tab[6]  = '{1, 4'd0,  0,    0, 0, 0};
    tab[7]  = '{0, 4'd9,  9,    1, 0, 1};
    tab[8]  = '{0, 4'd8,  98,   2, 0, 1};
    tab[9]  = '{0, 4'd7,  987,  3, 0, 1};
    tab[10] = '{0, 4'd6,  9876, 4, 0, 1};
    tab[11] = '{0, 4'd5,  9876, 4, 0, 0};
    tab[12] = '{0, 4'hC,  9876, 4, 1, 0};
    tab[13] = '{1, 4'd0,  0,    0, 0, 0};
    tab[14] = '{0, 4'd0,  0,    0, 0, 1};

    bus.key_any = 1'b0; bus.digit = 4'd0; bus.clear = 1'b0;
    rst = 1'b1;
    stbs = 0; first_stb = -1;
    for (int i = 0; i < 3; i++) step(i);
    rst = 1'b0;
    check_state("reset", 0, 0, 0);
    chk("reset stb", int'(bus.digit_stb), 0);

    for (int i = 0; i < 15; i++) begin
      if (tab[i].is_clear) do_clear();
      else press(tab[i].d, LAT + 3, LAT + 3);
      check_state($sformatf("vec%0d", i), tab[i].v, tab[i].n, tab[i].e);
      chk($sformatf("vec%0d stbs", i), stbs, tab[i].s);
      if (!tab[i].is_clear && tab[i].s == 1)
        chk($sformatf("vec%0d latency", i), first_stb, LAT);
    end

    // Held key with a changing digit, then clear while still held
    do_clear();
    stbs = 0; first_stb = -1;
    bus.key_any = 1'b1; bus.digit = 4'd4;
    for (int i = 0; i < LAT + 10; i++) begin
      if (i == LAT + 2) bus.digit = 4'd6;
      step(i);
    end
    check_state("held", 4, 1, 0);
    chk("held stbs", stbs, 1);
    do_clear();
    for (int i = 0; i < 5; i++) step(i + 1);
    check_state("held clear", 0, 0, 0);
    chk("held clear stbs", stbs, 0);
    bus.key_any = 1'b0;
    for (int i = 0; i < LAT + 3; i++) step(i);
    press(4'd5, LAT + 3, LAT + 3);
    check_state("repress", 5, 1, 0);
    chk("repress stbs", stbs, 1);

    // clear in the very cycle the digit would be accepted
    stbs = 0; first_stb = -1;
    bus.key_any = 1'b1; bus.digit = 4'd8;
    for (int i = 0; i < LAT + 3; i++) begin
      bus.clear = (i == LAT);
      step(i);
      bus.clear = 1'b0;
    end
    bus.key_any = 1'b0;
    for (int i = 0; i < LAT + 3; i++) step(i);
    check_state("clear prio", 0, 0, 0);
    chk("clear prio stbs", stbs, 0);

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    press(4'd3, DEB - 1, DEB + 4);
    check_state("glitch", 0, 0, 0);
    chk("glitch stbs", stbs, 0);
    press(4'd2, DEB + 2, DEB + 3);
    check_state("deb press", 2, 1, 0);
    chk("deb latency", first_stb, DEB);
    do_clear();
`endif

    mv = 0; mn = 0; merr = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_clear();
        mv = 0; mn = 0; merr = 0;
        chk($sformatf("rnd%0d clr stb", k), stbs, 0);
      end else begin
        d = int'($urandom_range(0, 11));
        model_press(d, s);
        press(4'(d), LAT + 2 + int'($urandom_range(0, 3)), LAT + 3 + int'($urandom_range(0, 2)));
        chk($sformatf("rnd%0d stbs", k), stbs, s);
      end
      check_state($sformatf("rnd%0d", k), mv, mn, merr);
    end

    rst = 1'b1;
    for (int i = 0; i < 2; i++) step(i);
    rst = 1'b0;
    check_state("rereset", 0, 0, 0);
    press(4'd6, LAT + 3, LAT + 3);
    check_state("after rereset", 6, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
